// File: rtl/msj_pwm_pkg.sv
// rtl/msj_pwm_pkg.sv - register map and status bit layout for the MSJ PWM bank
package msj_pwm_pkg;

    // Word addresses above the per-channel duty window
    localparam logic [7:0] REG_PERIOD    = 8'h40;
    localparam logic [7:0] REG_CTRL      = 8'h41;
    localparam logic [7:0] REG_STATUS    = 8'h42;
    localparam logic [7:0] REG_ESTOP_CLR = 8'h43;

    // Control register bits
    localparam int CTRL_ENABLE = 0;

    // Status register bits
    localparam int STATUS_ESTOP_LATCH = 0;
    localparam int STATUS_ESTOP_SYNC  = 1;
    localparam int STATUS_REL_ALL     = 2;

endpackage

// File: rtl/msj_debounce.sv
// rtl/msj_debounce.sv - two-flop synchroniser followed by a stable-count debouncer
module msj_debounce #(
    parameter int CYCLES = 50000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic din_i,
    output logic dout_o
);

    localparam int CW = (CYCLES > 2) ? $clog2(CYCLES) : 1;

    logic          sync1_q;
    logic          sync2_q;
    logic          dout_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          dout_d;

    // Accept the synchronised value once it has disagreed with the output for
    // CYCLES consecutive cycles; any agreement in between restarts the count.
    always_comb begin
        cnt_d  = '0;
        dout_d = dout_q;
        if (sync2_q != dout_q) begin
            if (cnt_q == CW'(CYCLES - 1)) begin
                dout_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchroniser chain, stable counter and accepted value
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            dout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= din_i;
            sync2_q <= sync1_q;
            dout_q  <= dout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout_o = dout_q;

endmodule

// File: rtl/msj_pwm_bank.sv
// rtl/msj_pwm_bank.sv - shadowed multi-channel PWM with debounced buttons and latched e-stop
module msj_pwm_bank
    import msj_pwm_pkg::*;
#(
    parameter int          NUM_CH          = 8,
    parameter int          PWM_WIDTH       = 12,
    parameter int          DEBOUNCE_CYCLES = 50000,
    parameter int unsigned PULL_DUTY       = 2048,
    parameter int unsigned RELEASE_DUTY    = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        address,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic              read,
    output logic [31:0]       readdata,
    input  logic              emergency_off,
    input  logic              release_all_button,
    input  logic [NUM_CH-1:0] release_buttons,
    input  logic [NUM_CH-1:0] pull_buttons,
    output logic [NUM_CH-1:0] pwm,
    output logic [1:0]        led
);

    logic [PWM_WIDTH-1:0] cnt_q;
    logic [PWM_WIDTH-1:0] cnt_d;
    logic [PWM_WIDTH-1:0] period_stg_q;
    logic [PWM_WIDTH-1:0] period_act_q;
    logic [PWM_WIDTH-1:0] duty_stg_q [NUM_CH];
    logic [PWM_WIDTH-1:0] duty_act_q [NUM_CH];
    logic                 enable_q;
    logic                 estop_q;
    logic                 estop_d;
    logic                 es_sync1_q;
    logic                 es_sync2_q;
    logic                 wrap;
    logic                 estop_clr;
    logic [NUM_CH-1:0]    pull_db;
    logic [NUM_CH-1:0]    rel_db;
    logic                 rel_all_db;
    logic [31:0]          eff_duty [NUM_CH];
    logic [NUM_CH-1:0]    pwm_d;
    logic [NUM_CH-1:0]    pwm_q;
    logic [31:0]          readdata_d;
    logic [31:0]          readdata_q;
    logic                 unused_wdata;

    assign unused_wdata = ^writedata[31:PWM_WIDTH];

    // Per-channel pull/release buttons plus the shared release-all button
    for (genvar i = 0; i < NUM_CH; i++) begin : g_btn
        msj_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_pull_db (
            .clk_i  (clock),
            .rst_i  (reset),
            .din_i  (pull_buttons[i]),
            .dout_o (pull_db[i])
        );
        msj_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_rel_db (
            .clk_i  (clock),
            .rst_i  (reset),
            .din_i  (release_buttons[i]),
            .dout_o (rel_db[i])
        );
    end

    msj_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_rel_all_db (
        .clk_i  (clock),
        .rst_i  (reset),
        .din_i  (release_all_button),
        .dout_o (rel_all_db)
    );

    // Period counter; the wrap cycle is also the shadow-copy cycle. Using >=
    // keeps period_active=0 wrapping every cycle.
    always_comb begin
        wrap  = (cnt_q >= period_act_q);
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end

    // E-stop latch: an asserted synchronised input always wins over a clear write
    always_comb begin
        estop_clr = write && (address == REG_ESTOP_CLR) && writedata[0];
        if (es_sync2_q) begin
            estop_d = 1'b1;
        end else if (estop_clr) begin
            estop_d = 1'b0;
        end else begin
            estop_d = estop_q;
        end
    end

    // Effective duty by priority; the synchronised e-stop is folded in so pwm
    // drops on the same edge that sets the latch. Compare at 32 bits because
    // the button duties may exceed the counter width.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            eff_duty[i] = 32'(duty_act_q[i]);
            if (estop_q || es_sync2_q || !enable_q) begin
                eff_duty[i] = '0;
            end else if (rel_all_db || rel_db[i]) begin
                eff_duty[i] = RELEASE_DUTY;
            end else if (pull_db[i]) begin
                eff_duty[i] = PULL_DUTY;
            end
            pwm_d[i] = (32'(cnt_q) < eff_duty[i]);
        end
    end

    // Register read mux; idle cycles return zero
    always_comb begin
        readdata_d = '0;
        if (read) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (address == 8'(i)) begin
                    readdata_d = 32'(duty_stg_q[i]);
                end
            end
            if (address == REG_PERIOD) begin
                readdata_d = 32'(period_stg_q);
            end
            if (address == REG_CTRL) begin
                readdata_d[CTRL_ENABLE] = enable_q;
            end
            if (address == REG_STATUS) begin
                readdata_d[STATUS_ESTOP_LATCH] = estop_q;
                readdata_d[STATUS_ESTOP_SYNC]  = es_sync2_q;
                readdata_d[STATUS_REL_ALL]     = rel_all_db;
            end
        end
    end

    // Counter, staging/active registers, control, e-stop and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q        <= '0;
            period_stg_q <= '1;
            period_act_q <= '1;
            enable_q     <= 1'b0;
            estop_q      <= 1'b0;
            es_sync1_q   <= 1'b0;
            es_sync2_q   <= 1'b0;
            pwm_q        <= '0;
            readdata_q   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_stg_q[i] <= '0;
                duty_act_q[i] <= '0;
            end
        end else begin
            cnt_q      <= cnt_d;
            es_sync1_q <= emergency_off;
            es_sync2_q <= es_sync1_q;
            estop_q    <= estop_d;
            pwm_q      <= pwm_d;
            readdata_q <= readdata_d;
            if (wrap) begin
                period_act_q <= period_stg_q;
                for (int i = 0; i < NUM_CH; i++) begin
                    duty_act_q[i] <= duty_stg_q[i];
                end
            end
            if (write) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (address == 8'(i)) begin
                        duty_stg_q[i] <= writedata[PWM_WIDTH-1:0];
                    end
                end
                if (address == REG_PERIOD) begin
                    period_stg_q <= writedata[PWM_WIDTH-1:0];
                end
                if (address == REG_CTRL) begin
                    enable_q <= writedata[CTRL_ENABLE];
                end
            end
        end
    end

    assign pwm      = pwm_q;
    assign readdata = readdata_q;
    assign led      = {enable_q & ~estop_q, estop_q};

endmodule
